des_round_engine: RTL and testbench



---
 rtl/des_pkg.sv | 103 ++++++++++
 rtl/des_f_function.sv | 27 ++
 rtl/des_round_engine.sv | 115 +++++++++++
 tb/tb_des_round_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation/expansion tables, S-boxes, round sizing and
// the round-engine state encoding, plus the fixed bit-shuffle helpers.
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int SUBKEY_W   = 48;
  localparam int RND_W      = $clog2(NUM_ROUNDS);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Table entries use DES numbering: entry n selects input bit n, bit 1 = MSB.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box is stored row-major: index = {outer bits, inner four bits}.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_TBL[i])];
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_TBL[i])];
    return o;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] d);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = d[5'(32 - E_TBL[i])];
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] d);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = d[5'(32 - P_TBL[i])];
    return o;
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K): expand R to 48 bits, mix in the subkey, squeeze
// through the eight S-boxes and apply P. Purely combinational.
module des_f_function
  import des_pkg::*;
(
  input  logic [31:0]         r,
  input  logic [SUBKEY_W-1:0] k,
  output logic [31:0]         f
);

  logic [47:0] x;
  logic [31:0] s_out;

  assign x = e_expand(r) ^ k;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
      logic [5:0] chunk;
      assign chunk = x[47 - 6*gi -: 6];
      // Outer bits pick the row, inner four bits pick the column.
      assign s_out[31 - 4*gi -: 4] = 4'(SBOX[gi][{chunk[5], chunk[0], chunk[4:1]}]);
    end
  endgenerate

  assign f = p_perm(s_out);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: IP on accept, one Feistel round per clock, FP into a held
// output register. Define DES_DECRYPT_EN to add the decrypt port (reversed subkeys).
module des_round_engine
  import des_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [63:0]                    in_block,
  input  logic [NUM_ROUNDS*SUBKEY_W-1:0] subkeys_in,
`ifdef DES_DECRYPT_EN
  input  logic                           decrypt,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [63:0]                    out_block
);

  state_t           state_reg, state_next;
  logic [RND_W-1:0] rnd_reg, rnd_next;
  logic [31:0]      l_reg, l_next;
  logic [31:0]      r_reg, r_next;
  logic [63:0]      out_block_reg, out_block_next;

  logic [SUBKEY_W-1:0] subkey_arr [NUM_ROUNDS];
  logic [RND_W-1:0]    key_idx;
  logic [31:0]         f_out;
  logic [63:0]         ip_out;

  generate
    for (genvar gi = 0; gi < NUM_ROUNDS; gi++) begin : g_subkey
      assign subkey_arr[gi] = subkeys_in[SUBKEY_W*gi +: SUBKEY_W];
    end
  endgenerate

`ifdef DES_DECRYPT_EN
  logic decrypt_reg, decrypt_next;

  // Decryption is the same network walked with the key schedule reversed.
  assign key_idx = decrypt_reg ? (LAST_RND - rnd_reg) : rnd_reg;

  always_ff @(posedge clk) begin
    if (rst) decrypt_reg <= 1'b0;
    else     decrypt_reg <= decrypt_next;
  end

  always_comb begin
    decrypt_next = decrypt_reg;
    if (state_reg == IDLE && in_valid) decrypt_next = decrypt;
  end
`else
  assign key_idx = rnd_reg;
`endif

  des_f_function u_f (
    .r (r_reg),
    .k (subkey_arr[key_idx]),
    .f (f_out)
  );

  assign ip_out = ip_perm(in_block);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rnd_reg       <= '0;
      l_reg         <= '0;
      r_reg         <= '0;
      out_block_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rnd_reg       <= rnd_next;
      l_reg         <= l_next;
      r_reg         <= r_next;
      out_block_reg <= out_block_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rnd_next       = rnd_reg;
    l_next         = l_reg;
    r_next         = r_reg;
    out_block_next = out_block_reg;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          {l_next, r_next} = ip_out;
          rnd_next         = '0;
          state_next       = ROUND;
        end
      end
      ROUND: begin
        l_next   = r_reg;
        r_next   = l_reg ^ f_out;
        rnd_next = rnd_reg + 1'b1;
        if (rnd_reg == LAST_RND) begin
          state_next = DONE;
          // Final half-swap is undone here: FP sees {R16, L16}.
          out_block_next = fp_perm({l_reg ^ f_out, r_reg});
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_block = out_block_reg;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine: subkeys come from a local key schedule,
// expected ciphertexts are queued on issue and popped when out_valid appears.
module tb_des_round_engine;
  import des_pkg::*;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] ZERO_CT = 64'h8CA64DE9C1B123A7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_block = '0;
  logic [767:0] subkeys_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_block;
`ifdef DES_DECRYPT_EN
  logic         decrypt = 1'b0;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];

  des_round_engine dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .subkeys_in (subkeys_in),
`ifdef DES_DECRYPT_EN
    .decrypt    (decrypt),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block)
  );

  always #5 clk = ~clk;

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [47:0]  k;
    logic [767:0] ks;
    cd = '0;
    ks = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      k = '0;
      for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - PC2[j])];
      ks[10'(48 * r) +: 48] = k;
    end
    return ks;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the block presented; edge 1 is the accept edge.
  task automatic wait_valid(input bit keep_valid, input logic [63:0] alt_block,
                            output int lat, output logic mid_ready);
    lat = 0;
    mid_ready = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (keep_valid) in_block = alt_block;
        else            in_valid = 1'b0;
      end
      if (i == 8) mid_ready = in_ready;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop_compare(input string tag, input int lat);
    logic [63:0] expv;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    $display("txn %s: out_block=%h expected=%h latency=%0d", tag, out_block, expv, lat);
    check(tag, out_block, expv);
  endtask

  initial begin
    int          lat;
    logic        mid;
    logic        stable;
    logic        seen;
    logic [63:0] held;

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_block", out_block, 64'd0);

    // Known answer, single-cycle output pulse
    subkeys_in = key_sched(KAT_KEY);
    in_block = KAT_PT; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(KAT_CT);
    wait_valid(1'b0, '0, lat, mid);
    check("kat_latency", 64'(lat), 64'd17);
    check("kat_round_in_ready", 64'(mid), 64'd0);
    pop_compare("kat_out", lat);
    @(negedge clk);
    check("kat_valid_pulse", 64'(out_valid), 64'd0);
    check("kat_idle_ready", 64'(in_ready), 64'd1);
    check("kat_hold_idle", out_block, KAT_CT);

    // All-zero key and block
    subkeys_in = key_sched(64'd0);
    in_block = 64'd0; in_valid = 1'b1;
    exp_q.push_back(ZERO_CT);
    wait_valid(1'b0, '0, lat, mid);
    check("zero_latency", 64'(lat), 64'd17);
    pop_compare("zero_out", lat);
    @(negedge clk);

    // Backpressure: result must hold for 10 cycles
    subkeys_in = key_sched(KAT_KEY);
    in_block = KAT_PT; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(KAT_CT);
    wait_valid(1'b0, '0, lat, mid);
    check("bp_latency", 64'(lat), 64'd17);
    pop_compare("bp_out", lat);
    held = out_block;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_block !== held || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    // in_valid and out_ready together in DONE: only the output handshake completes
    in_block = KAT_PT; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(KAT_CT);
    @(negedge clk);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    wait_valid(1'b0, '0, lat, mid);
    check("bp_next_latency", 64'(lat), 64'd17);
    pop_compare("bp_next_out", lat);
    @(negedge clk);

    // in_valid held with a different block during the rounds
    in_block = KAT_PT; in_valid = 1'b1;
    exp_q.push_back(KAT_CT);
    wait_valid(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, lat, mid);
    check("hold_latency", 64'(lat), 64'd17);
    check("hold_round_in_ready", 64'(mid), 64'd0);
    pop_compare("hold_out", lat);
    @(negedge clk);
    check("hold_not_accepted", 64'(in_ready), 64'd1);
    check("hold_valid_low", 64'(out_valid), 64'd0);
    in_block = KAT_PT;
    exp_q.push_back(KAT_CT);
    wait_valid(1'b0, '0, lat, mid);
    check("hold_second_latency", 64'(lat), 64'd17);
    pop_compare("hold_second_out", lat);
    @(negedge clk);

    // Reset during round 7 discards the block
    in_block = KAT_PT; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_block", out_block, 64'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    $display("txn abort: block dropped, out_valid seen=%0d", seen);

`ifdef DES_DECRYPT_EN
    // Decrypt the known-answer ciphertext back to plaintext
    decrypt = 1'b1;
    subkeys_in = key_sched(KAT_KEY);
    in_block = KAT_CT; in_valid = 1'b1;
    exp_q.push_back(KAT_PT);
    wait_valid(1'b0, '0, lat, mid);
    check("dec_latency", 64'(lat), 64'd17);
    pop_compare("dec_out", lat);
    @(negedge clk);
    decrypt = 1'b0;
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
